// File: rtl/decode_stage_if.sv
// Bundles the decode stage's bus signals.
// The bundle covers the fetch-side handshake, the regfile read and
// writeback taps, and the execute-side handshake with decoded fields.
//
//   slave  modport : the decode stage's view.
//   master modport : the surrounding pipeline's view. This covers fetch,
//                    the regfile, writeback and execute.
//
// Signals:
//   inValid/inReady/inInstr/inPc  fetch handshake and instruction
//   flush                         redirect, drops the held instruction
//   readReg1/2, readData1/2       regfile read address / registered data
//   wbWrite/wbReg/wbData          writeback port, as seen by the regfile
//   outValid/outReady             execute handshake
//   outPc .. outIllegal           decoded instruction and operands
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  inValid;
  logic                  inReady;
  logic [31:0]           inInstr;
  logic [XLEN-1:0]       inPc;
  logic                  flush;
  logic [REG_ADDR_W-1:0] readReg1;
  logic [REG_ADDR_W-1:0] readReg2;
  logic [XLEN-1:0]       readData1;
  logic [XLEN-1:0]       readData2;
  logic                  wbWrite;
  logic [REG_ADDR_W-1:0] wbReg;
  logic [XLEN-1:0]       wbData;
  logic                  outValid;
  logic                  outReady;
  logic [XLEN-1:0]       outPc;
  logic [XLEN-1:0]       outRs1Val;
  logic [XLEN-1:0]       outRs2Val;
  logic [XLEN-1:0]       outImm;
  logic [REG_ADDR_W-1:0] outRd;
  logic [6:0]            outOpcode;
  logic [2:0]            outFunct3;
  logic                  outFunct7b5;
  logic                  outRegWrite;
  logic                  outIllegal;

  modport master (
    output inValid, inInstr, inPc, flush, readData1, readData2,
           wbWrite, wbReg, wbData, outReady,
    input  inReady, readReg1, readReg2, outValid, outPc, outRs1Val,
           outRs2Val, outImm, outRd, outOpcode, outFunct3, outFunct7b5,
           outRegWrite, outIllegal
  );

  modport slave (
    input  inValid, inInstr, inPc, flush, readData1, readData2,
           wbWrite, wbReg, wbData, outReady,
    output inReady, readReg1, readReg2, outValid, outPc, outRs1Val,
           outRs2Val, outImm, outRd, outOpcode, outFunct3, outFunct7b5,
           outRegWrite, outIllegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage.
// The stage sits directly upstream of the register file. It accepts one
// instruction over a valid/ready handshake and drives the regfile read
// addresses combinationally. It captures the regfile's registered read data
// one cycle later. It then presents the decoded fields, the immediate and the
// operands to execute over a second valid/ready handshake.
//
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous, active-high; clears all state
//   bus    decode_stage_if.slave (fetch, regfile, writeback, execute)
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : writeback hits are captured every edge and forwarded into the
//               operands, so no hazard stall is ever needed.
//   undefined : a writeback hit forces a REREAD cycle. The regfile then
//               re-reads the just-written value before outValid is raised.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

`ifdef RF_BYPASS_EN
  typedef enum logic [1:0] {EMPTY, VALID} state_t;
`else
  typedef enum logic [1:0] {EMPTY, VALID, REREAD} state_t;
`endif

  state_t                state;
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic                  funct7b5_q;
  logic                  reg_write_q;
  logic                  illegal_q;

  logic                  in_ready;
  logic                  accept;
  logic                  consume;
  logic [REG_ADDR_W-1:0] read_reg1;
  logic [REG_ADDR_W-1:0] read_reg2;
  logic                  hit1;
  logic                  hit2;

  logic [XLEN-1:0]       dec_imm;
  logic                  dec_reg_write;
  logic                  dec_illegal;

  assign consume  = out_valid && bus.outReady;
  assign in_ready = !bus.flush && ((state == EMPTY) || consume);
  assign accept   = bus.inValid && in_ready;

  // The held rs indices are cleared whenever the stage empties.
  // This makes the read addresses fall to 0 with no instruction in flight.
  assign read_reg1 = accept ? bus.inInstr[19:15] : rs1_q;
  assign read_reg2 = accept ? bus.inInstr[24:20] : rs2_q;

  // A writeback landing on an address the regfile samples this edge.
  // The regfile returns the stale value in that case.
  assign hit1 = bus.wbWrite && (bus.wbReg == read_reg1) && (read_reg1 != '0);
  assign hit2 = bus.wbWrite && (bus.wbReg == read_reg2) && (read_reg2 != '0);

  // Immediate, rd-write and legality decode of the incoming instruction.
  // Only the listed RV32I opcodes are legal. Anything else travels
  // downstream flagged illegal, with a zero immediate and no register write.
  always_comb begin
    dec_imm       = '0;
    dec_reg_write = 1'b1;
    dec_illegal   = 1'b0;
    case (bus.inInstr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        dec_imm = {{20{bus.inInstr[31]}}, bus.inInstr[31:20]};
      7'b0100011: begin
        dec_imm       = {{20{bus.inInstr[31]}}, bus.inInstr[31:25], bus.inInstr[11:7]};
        dec_reg_write = 1'b0;
      end
      7'b1100011: begin
        dec_imm       = {{19{bus.inInstr[31]}}, bus.inInstr[31], bus.inInstr[7],
                         bus.inInstr[30:25], bus.inInstr[11:8], 1'b0};
        dec_reg_write = 1'b0;
      end
      7'b0110111, 7'b0010111:
        dec_imm = {bus.inInstr[31:12], 12'b0};
      7'b1101111:
        dec_imm = {{11{bus.inInstr[31]}}, bus.inInstr[31], bus.inInstr[19:12],
                   bus.inInstr[20], bus.inInstr[30:21], 1'b0};
      7'b0110011:
        dec_imm = '0;
      default: begin
        dec_reg_write = 1'b0;
        dec_illegal   = 1'b1;
      end
    endcase
  end

`ifdef RF_BYPASS_EN
  logic            hit1_q;
  logic            hit2_q;
  logic [XLEN-1:0] wb_data_q;

  // Hits and writeback data are captured on every edge.
  // The captured value is exactly what the regfile missed on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      wb_data_q <= '0;
    end else begin
      hit1_q    <= hit1;
      hit2_q    <= hit2;
      wb_data_q <= bus.wbData;
    end
  end

  assign bus.outRs1Val = (rs1_q == '0) ? '0 : (hit1_q ? wb_data_q : bus.readData1);
  assign bus.outRs2Val = (rs2_q == '0) ? '0 : (hit2_q ? wb_data_q : bus.readData2);
`else
  // Without the bypass, new writeback values reach the operands only through
  // a regfile re-read.
  logic unused_wb_data;
  assign unused_wb_data = ^bus.wbData;

  // x0 is forced to zero because the regfile does not protect x0 writes.
  assign bus.outRs1Val = (rs1_q == '0) ? '0 : bus.readData1;
  assign bus.outRs2Val = (rs2_q == '0) ? '0 : bus.readData2;
`endif

  // Holding FSM.
  // A flush always wins. An accept loads the decoded fields. A consume with
  // no accept empties the stage. Without the bypass, any hit on the edge the
  // regfile samples our addresses sends the stage to REREAD, and it stays
  // there until an edge passes with no hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (accept) begin
      rs1_q       <= bus.inInstr[19:15];
      rs2_q       <= bus.inInstr[24:20];
      pc_q        <= bus.inPc;
      imm_q       <= dec_imm;
      rd_q        <= dec_reg_write ? bus.inInstr[11:7] : '0;
      opcode_q    <= bus.inInstr[6:0];
      funct3_q    <= bus.inInstr[14:12];
      funct7b5_q  <= bus.inInstr[30];
      reg_write_q <= dec_reg_write;
      illegal_q   <= dec_illegal;
`ifdef RF_BYPASS_EN
      state     <= VALID;
      out_valid <= 1'b1;
`else
      if (hit1 || hit2) begin
        state     <= REREAD;
        out_valid <= 1'b0;
      end else begin
        state     <= VALID;
        out_valid <= 1'b1;
      end
`endif
    end else begin
      case (state)
        VALID: begin
          if (consume) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
          end
`ifndef RF_BYPASS_EN
          else if (hit1 || hit2) begin
            state     <= REREAD;
            out_valid <= 1'b0;
          end
`endif
        end
`ifndef RF_BYPASS_EN
        REREAD: begin
          if (!(hit1 || hit2)) begin
            state     <= VALID;
            out_valid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.inReady     = in_ready;
  assign bus.readReg1    = read_reg1;
  assign bus.readReg2    = read_reg2;
  assign bus.outValid    = out_valid;
  assign bus.outPc       = pc_q;
  assign bus.outImm      = imm_q;
  assign bus.outRd       = rd_q;
  assign bus.outOpcode   = opcode_q;
  assign bus.outFunct3   = funct3_q;
  assign bus.outFunct7b5 = funct7b5_q;
  assign bus.outRegWrite = reg_write_q;
  assign bus.outIllegal  = illegal_q;

endmodule
